// File: rtl/reg_bank_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_arbiter_pkg
// Brief    : Shared operation codes, FSM states and helpers for the arbiter.
// Revision : 1.0
// ============================================================================
package reg_bank_arbiter_pkg;

    localparam logic [1:0] OP_DEC  = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    // Load and clear always occupy exactly one enable cycle.
    function automatic logic is_single_shot(input logic [1:0] op);
        return (op == OP_LOAD) || (op == OP_CLR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bank_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Two-way round-robin arbiter; pointer toggles on each advance.
// Revision : 1.0
// ============================================================================
module rr_arbiter2 (
    input  logic       Clock,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    // ptr_q == 0 favours requester 0 (A) when both request.
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = ~ptr_q;
        end
    end

    always_ff @(posedge Clock) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_arbiter
// Brief    : Round-robin burst arbiter driving a shared register bank.
// Revision : 1.0
// ============================================================================
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int NREG  = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 4
) (
    input  logic             Clock,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [SEL_W-1:0] a_sel,
    input  logic [1:0]       a_op,
    input  logic [15:0]      a_data,
    input  logic [CNT_W-1:0] a_count,
    output logic             a_done,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [SEL_W-1:0] b_sel,
    input  logic [1:0]       b_op,
    input  logic [15:0]      b_data,
    input  logic [CNT_W-1:0] b_count,
    output logic             b_done,
    output logic [NREG-1:0]  reg_E,
    output logic [1:0]       reg_FunSel,
    output logic [15:0]      reg_I,
    output logic             busy,
    output logic             sel_err
);

    state_e           state_q;
    logic             owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic [NREG-1:0]  reg_E_q;
    logic [1:0]       funsel_q;
    logic [15:0]      reg_I_q;
    logic             a_done_q;
    logic             b_done_q;
    logic             sel_err_q;

    logic [1:0]       gnt;
    logic             accept_a;
    logic             accept_b;
    logic             accept;
    logic [SEL_W-1:0] sel_m;
    logic [1:0]       op_m;
    logic [15:0]      data_m;
    logic [CNT_W-1:0] count_m;
    logic [CNT_W-1:0] len_d;
    logic [NREG-1:0]  onehot_d;
    logic             oob_d;

    rr_arbiter2 u_rr (
        .Clock     (Clock),
        .rst       (rst),
        .req_i     ({b_valid, a_valid}),
        .advance_i (accept),
        .gnt_o     (gnt)
    );

    // Ready is held off during reset so nothing is accepted on a reset edge.
    assign a_ready  = (state_q == IDLE) && !rst && gnt[0];
    assign b_ready  = (state_q == IDLE) && !rst && gnt[1];
    assign accept_a = a_valid && a_ready;
    assign accept_b = b_valid && b_ready;
    assign accept   = accept_a || accept_b;

    assign sel_m   = accept_b ? b_sel   : a_sel;
    assign op_m    = accept_b ? b_op    : a_op;
    assign data_m  = accept_b ? b_data  : a_data;
    assign count_m = accept_b ? b_count : a_count;

    always_comb begin
        len_d = count_m;
        if (is_single_shot(op_m) || (count_m == '0)) begin
            len_d = CNT_W'(1);
        end
    end

    assign oob_d = (int'(sel_m) >= NREG);

    always_comb begin
        onehot_d = '0;
        for (int i = 0; i < NREG; i++) begin
            if (sel_m == SEL_W'(i)) begin
                onehot_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            cnt_q     <= '0;
            reg_E_q   <= '0;
            funsel_q  <= 2'b00;
            reg_I_q   <= 16'h0000;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            sel_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q   <= ISSUE;
                        owner_q   <= accept_b;
                        cnt_q     <= len_d;
                        reg_E_q   <= onehot_d;
                        funsel_q  <= op_m;
                        reg_I_q   <= data_m;
                        sel_err_q <= oob_d;
                        if (len_d == CNT_W'(1)) begin
                            a_done_q <= !accept_b;
                            b_done_q <= accept_b;
                        end
                    end
                end
                ISSUE: begin
                    // cnt_q counts enable cycles still to go, including this one.
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                        reg_E_q <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(2)) begin
                            a_done_q <= !owner_q;
                            b_done_q <= owner_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign reg_E      = reg_E_q;
    assign reg_FunSel = funsel_q;
    assign reg_I      = reg_I_q;
    assign a_done     = a_done_q;
    assign b_done     = b_done_q;
    assign sel_err    = sel_err_q;
    assign busy       = (state_q == ISSUE);

endmodule
`default_nettype wire
